// File: rtl/fifo_line_ctrl.sv
// Line-buffer controller: pairs each pixel with the pixel one line above it,
// using an external 8-bit FIFO that always holds exactly one image line.
`timescale 1ns/1ps
module fifo_line_ctrl #(
    parameter int LINE_W = 32,
    parameter int IMG_H  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_pixel,
    output logic       m_valid,
    output logic [7:0] m_cur,
    output logic [7:0] m_prev,
    output logic [5:0] m_col,
    output logic [9:0] m_row,
    output logic       frame_done,
    output logic       err_underflow,
    output logic       fifo_rst,
    output logic [7:0] fifo_din,
    output logic       fifo_wr_en,
    output logic       fifo_rd_en,
    input  logic [7:0] fifo_dout,
    input  logic [6:0] fifo_data_count,
    input  logic       fifo_full,
    input  logic       fifo_empty
);
    typedef enum logic [1:0] {FILL, STREAM, DRAIN, DONE} state_t;

    localparam logic [5:0] COL_LAST = 6'(LINE_W - 1);
    localparam logic [9:0] ROW_LAST = 10'(IMG_H - 1);

    state_t     state_reg;
    logic [5:0] col_reg;
    logic [9:0] row_reg;
    logic       m_valid_reg;
    logic       prev_zero_reg;
    logic [7:0] m_cur_reg;
    logic [5:0] m_col_reg;
    logic [9:0] m_row_reg;
    logic       frame_done_reg;
    logic       err_underflow_reg;

    logic in_flow;
    logic has_data;
    logic accept;
    logic col_last;
    logic last_pixel;

    assign in_flow    = (state_reg == FILL) || (state_reg == STREAM);
    // A read is only issued when both status inputs agree data is present.
    assign has_data   = !fifo_empty && (fifo_data_count != 7'd0);
    assign s_ready    = in_flow && !fifo_full && !rst;
    assign accept     = s_valid && s_ready;
    assign col_last   = (col_reg == COL_LAST);
    assign last_pixel = col_last && (row_reg == ROW_LAST);

    assign fifo_din   = in_flow ? s_pixel : 8'd0;
    assign fifo_wr_en = accept;
    assign fifo_rd_en = !rst && (((state_reg == STREAM) && accept && has_data) ||
                                 ((state_reg == DRAIN) && has_data));
    assign fifo_rst   = rst || (state_reg == DONE);

    // The FIFO presents read data one cycle after the read, which is exactly
    // the cycle the registered pair is shown, so the previous-line pixel is
    // taken straight from fifo_dout.
    assign m_valid       = m_valid_reg;
    assign m_cur         = m_cur_reg;
    assign m_prev        = (m_valid_reg && !prev_zero_reg) ? fifo_dout : 8'd0;
    assign m_col         = m_col_reg;
    assign m_row         = m_row_reg;
    assign frame_done    = frame_done_reg;
    assign err_underflow = err_underflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= FILL;
            col_reg           <= 6'd0;
            row_reg           <= 10'd0;
            m_valid_reg       <= 1'b0;
            prev_zero_reg     <= 1'b0;
            m_cur_reg         <= 8'd0;
            m_col_reg         <= 6'd0;
            m_row_reg         <= 10'd0;
            frame_done_reg    <= 1'b0;
            err_underflow_reg <= 1'b0;
        end else begin
            m_valid_reg    <= 1'b0;
            frame_done_reg <= 1'b0;

            if (accept) begin
                if (col_last) begin
                    col_reg <= 6'd0;
                    row_reg <= row_reg + 10'd1;
                end else begin
                    col_reg <= col_reg + 6'd1;
                end
            end

            case (state_reg)
                FILL: begin
                    if (accept && col_last) begin
                        state_reg <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        m_valid_reg   <= 1'b1;
                        m_cur_reg     <= s_pixel;
                        m_col_reg     <= col_reg;
                        m_row_reg     <= row_reg;
                        prev_zero_reg <= !has_data;
                        if (!has_data) begin
                            err_underflow_reg <= 1'b1;
                        end
                        if (last_pixel) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!has_data) begin
                        state_reg      <= DONE;
                        frame_done_reg <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= FILL;
                    col_reg   <= 6'd0;
                    row_reg   <= 10'd0;
                end
                default: state_reg <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_line_ctrl.sv
// Bench for fifo_line_ctrl: behavioural FIFO, frame-level pair model, directed
// scenarios with randomized valid gaps and pixel values.
`timescale 1ns/1ps
module tb_fifo_line_ctrl;
    localparam int LINE_W = 4;
    localparam int IMG_H  = 3;
    localparam int NPIX   = LINE_W * IMG_H;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_pixel;
    logic       m_valid;
    logic [7:0] m_cur;
    logic [7:0] m_prev;
    logic [5:0] m_col;
    logic [9:0] m_row;
    logic       frame_done;
    logic       err_underflow;
    logic       fifo_rst;
    logic [7:0] fifo_din;
    logic       fifo_wr_en;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout = 8'd0;
    logic [6:0] fifo_data_count;
    logic       fifo_full;
    logic       fifo_empty;

    logic       force_empty = 1'b0;
    logic       force_full  = 1'b0;
    logic [7:0] fq[$];
    logic [6:0] fcnt = 7'd0;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    int fd_cnt = 0;
    int mv_cnt = 0;
    int idx    = 0;
    bit check_pairs = 1'b1;
    logic [7:0] frame_pix [NPIX];

    fifo_line_ctrl #(.LINE_W(LINE_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
        .m_valid(m_valid), .m_cur(m_cur), .m_prev(m_prev),
        .m_col(m_col), .m_row(m_row),
        .frame_done(frame_done), .err_underflow(err_underflow),
        .fifo_rst(fifo_rst), .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout), .fifo_data_count(fifo_data_count),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    always #5 clk = ~clk;

    // 64-entry FIFO, read data registered one cycle after rd_en.
    always @(posedge clk) begin
        if (fifo_rst) begin
            fq.delete();
            fifo_dout <= 8'd0;
        end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
            if (fifo_wr_en && fq.size() < 64) fq.push_back(fifo_din);
        end
        fcnt <= 7'(fq.size());
    end
    assign fifo_data_count = fcnt;
    assign fifo_empty      = (fcnt == 7'd0) || force_empty;
    assign fifo_full       = (fcnt >= 7'd64) || force_full;

    always @(negedge clk) begin
        if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (m_valid)    mv_cnt <= mv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock with the given input; model derives the expected pair from
    // the raster position of each accepted pixel.
    task automatic cycle(input bit v, input logic [7:0] px, output bit acc);
        bit         exp_v;
        logic [7:0] exp_cur, exp_prev;
        int         r, c;
        s_valid = v;
        s_pixel = px;
        exp_v = 1'b0;
        exp_cur = 8'd0;
        exp_prev = 8'd0;
        r = 0;
        c = 0;
        @(negedge clk);
        acc = s_valid && s_ready;
        chk("wr_en", fifo_wr_en, acc);
        chk("no_wr_when_full", fifo_wr_en && fifo_full, 0);
        if (acc) begin
            r = idx / LINE_W;
            c = idx % LINE_W;
            frame_pix[idx] = px;
            if (r >= 1) begin
                exp_v    = 1'b1;
                exp_cur  = px;
                exp_prev = force_empty ? 8'd0 : frame_pix[idx - LINE_W];
            end
            idx++;
        end
        @(posedge clk);
        #1;
        chk("m_valid", m_valid, exp_v);
        if (exp_v && check_pairs) begin
            chk("m_cur", m_cur, exp_cur);
            chk("m_prev", m_prev, exp_prev);
            chk("m_col", m_col, c);
            chk("m_row", m_row, r);
        end
        $display("cycle v=%0b px=%0d acc=%0b m_valid=%0b cur=%0d prev=%0d col=%0d row=%0d",
                 v, px, acc, m_valid, m_cur, m_prev, m_col, m_row);
    endtask

    task automatic feed(input int first, input int last, input bit rnd_valid, input bit rnd_pix);
        bit acc;
        logic [7:0] px;
        for (int p = first; p <= last; p++) begin
            int guard = 0;
            px = rnd_pix ? 8'($urandom) : 8'(p);
            acc = 1'b0;
            while (!acc && guard < 200) begin
                cycle(rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1, px, acc);
                guard++;
            end
            if (!acc) begin
                chk("accept_timeout", 0, 1);
                return;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic finish_frame();
        int n0 = rd_cnt;
        int f0 = fd_cnt;
        bit seen = 1'b0;
        s_valid = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                seen = 1'b1;
                chk("fifo_rst_in_done", fifo_rst, 1);
            end
        end
        chk("frame_done_seen", seen, 1);
        @(posedge clk);
        #1;
        chk("drain_reads", rd_cnt - n0, LINE_W);
        chk("frame_done_once", fd_cnt - f0, 1);
        chk("count_after_frame", fifo_data_count, 0);
        $display("frame end: drain_reads=%0d frame_done_pulses=%0d count=%0d",
                 rd_cnt - n0, fd_cnt - f0, fifo_data_count);
        idx = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        s_pixel = 8'd0;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_fifo_rst", fifo_rst, 1);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_cur", m_cur, 0);
        chk("rst_m_prev", m_prev, 0);
        chk("rst_m_col", m_col, 0);
        chk("rst_m_row", m_row, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err_underflow, 0);
        rst = 1'b0;
        idx = 0;
        $display("reset applied");
    endtask

    initial begin
        int mv0, fd0;
        bit acc;
        rst = 1'b1;
        s_valid = 1'b0;
        s_pixel = 8'd0;
        @(posedge clk);
        #1;
        do_reset();

        // Back-to-back frame 0..11, then a second identical frame.
        feed(0, NPIX - 1, 1'b0, 1'b0);
        finish_frame();
        mv0 = mv_cnt;
        feed(0, NPIX - 1, 1'b0, 1'b0);
        finish_frame();
        chk("pairs_frame2", mv_cnt - mv0, LINE_W * (IMG_H - 1));

        // Random valid gaps, sequential then random pixels.
        mv0 = mv_cnt;
        feed(0, NPIX - 1, 1'b1, 1'b0);
        finish_frame();
        chk("pairs_gappy", mv_cnt - mv0, LINE_W * (IMG_H - 1));
        mv0 = mv_cnt;
        feed(0, NPIX - 1, 1'b1, 1'b1);
        finish_frame();
        chk("pairs_random", mv_cnt - mv0, LINE_W * (IMG_H - 1));

        // Reset mid-frame abandons it; the next frame is clean.
        fd0 = fd_cnt;
        feed(0, 6, 1'b0, 1'b0);
        do_reset();
        chk("no_done_on_abort", fd_cnt - fd0, 0);
        chk("fifo_flushed", fifo_data_count, 0);
        feed(0, NPIX - 1, 1'b0, 1'b0);
        finish_frame();

        // Empty FIFO on the first streaming read.
        do_reset();
        feed(0, LINE_W - 1, 1'b0, 1'b0);
        force_empty = 1'b1;
        cycle(1'b1, 8'(LINE_W), acc);
        force_empty = 1'b0;
        chk("underflow_set", err_underflow, 1);
        check_pairs = 1'b0;
        feed(LINE_W + 1, LINE_W + 4, 1'b0, 1'b0);
        check_pairs = 1'b1;
        chk("underflow_sticky", err_underflow, 1);
        do_reset();

        // Full FIFO stalls acceptance in FILL without losing pixels.
        feed(0, 1, 1'b0, 1'b0);
        force_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 8'd2, acc);
            chk("blocked_when_full", acc, 0);
        end
        force_full = 1'b0;
        feed(2, NPIX - 1, 1'b0, 1'b0);
        finish_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
